// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes,
// ALU class codes and ALU operand select values.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC      = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_TRAP      = 4'd9
  } state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  // Dispatch out of DECODE; anything unrecognised traps.
  function automatic state_t decode_next(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_STORE: return S_MEM_ADDR;
      OP_RTYPE, OP_IALU: return S_EXEC;
      OP_BEQ:            return S_BRANCH;
      default:           return S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle processor: sequences fetch, decode,
// execute, memory and write-back and drives all datapath enables and selects.
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        pc_source,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [3:0]  funct,
  output logic        illegal,
  output logic [3:0]  state
);

  state_t     state_q, state_d;
  logic [3:0] funct_q;
  logic       itype_q;
  logic [6:0] opcode;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE:    state_d = decode_next(opcode);
      S_MEM_ADDR:  state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC:      state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
  end

  // funct and the R/I flag are captured only on the DECODE edge so they stay
  // stable through EXEC regardless of later IR activity.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      funct_q <= 4'b0000;
      itype_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        funct_q <= {instr[30] & (opcode != OP_IALU), instr[14:12]};
        itype_q <= (opcode == OP_IALU);
      end
    end
  end

  logic pc_write_s, pc_write_cond_s, mem_read_s, mem_write_s, ir_write_s, reg_write_s;

  always_comb begin
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    pc_source       = 1'b0;
    i_or_d          = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_write_s     = 1'b0;
    mem_to_reg      = 1'b0;
    alu_src_a       = SRC_A_PC;
    alu_src_b       = SRC_B_RS2;
    alu_op          = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read_s = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_READ: begin
        mem_read_s = 1'b1;
        i_or_d     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_s = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_s = 1'b1;
        i_or_d      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = itype_q ? SRC_B_IMM : SRC_B_RS2;
        alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: reg_write_s = 1'b1;
      S_BRANCH: begin
        alu_src_a       = SRC_A_RS1;
        alu_op          = ALU_SUB;
        pc_write_cond_s = 1'b1;
        pc_source       = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset_n so nothing is written while reset is held.
  assign pc_write      = pc_write_s      & reset_n;
  assign pc_write_cond = pc_write_cond_s & reset_n;
  assign mem_read      = mem_read_s      & reset_n;
  assign mem_write     = mem_write_s     & reset_n;
  assign ir_write      = ir_write_s      & reset_n;
  assign reg_write     = reg_write_s     & reset_n;

  assign funct   = funct_q;
  assign illegal = (state_q == S_TRAP);
  assign state   = state_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle processor variant: sequences each instruction through fetch, decode, execute, memory and write-back, and drives all datapath enables and mux selects. It is the producer side of the ALUOp/Funct interface: it emits the 2-bit ALU class code and the 4-bit Funct field (instr[30], instr[14:12]) that the ALU control decoder turns into an ALU operation. Memory accesses use a ready handshake, so fetch and data accesses may take any number of cycles.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- instr  in  32  IR contents; valid from DECODE onward
- mem_ready  in  1  memory completed current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load when ALU zero (datapath ANDs with zero)
- pc_source  out  1  0 = ALU result, 1 = ALUOut (branch target)
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- ir_write  out  1  load IR and old_pc
- reg_write  out  1  register file write
- mem_to_reg  out  1  write-back source: 0 = ALUOut, 1 = MDR
- alu_src_a  out  2  00 PC, 01 rs1, 10 old_pc
- alu_src_b  out  2  00 rs2, 01 constant 4, 10 immediate
- alu_op  out  2  00 add, 01 subtract (branch), 10 use Funct
- funct  out  4  registered {instr[30], instr[14:12]}
- illegal  out  1  sticky unsupported-opcode flag
- state  out  4  current state (debug)

## Operation
- Opcodes: R-type 0110011, I-ALU 0010011, load 0000011, store 0100011, beq 1100011; anything else is illegal.
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC 6, ALU_WB 7, BRANCH 8, TRAP 9.
- FETCH: mem_read=1, src_a=00, src_b=01, alu_op=00; ir_write=pc_write=mem_ready; stays in FETCH until mem_ready, then DECODE.
- DECODE: src_a=10, src_b=10, alu_op=00 (branch target into ALUOut); funct register loads {instr[30], instr[14:12]}; for I-ALU, funct[3] loads 0. Next: load/store→MEM_ADDR, R/I-ALU→EXEC, beq→BRANCH, else TRAP.
- MEM_ADDR: src_a=01, src_b=10, alu_op=00; next MEM_READ (load) or MEM_WRITE (store).
- MEM_READ: mem_read=1, i_or_d=1; holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1; next FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1; holds until mem_ready, then FETCH.
- EXEC: src_a=01, src_b=00 (R) or 10 (I), alu_op=10; next ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0; next FETCH.
- BRANCH: src_a=01, src_b=00, alu_op=01, pc_write_cond=1, pc_source=1; next FETCH.
- TRAP: all enables 0, illegal=1; remains until reset.
- Any output not listed for a state is 0.

## Timing
- Outputs are Moore: decoded from state only (plus registered funct); no input-to-output combinational path except ir_write/pc_write from mem_ready in FETCH.
- Reset (async assert, sync to clk on release): state=FETCH, funct=0000, illegal=0; while reset_n is low all write/strobe outputs (pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write) forced 0. Reset mid-instruction abandons it; no partial writes.
- Latency with mem_ready always 1: load 5 cycles, R/I-ALU 4, store 4, beq 3.
- Each extra cycle of mem_ready low adds one cycle in FETCH/MEM_READ/MEM_WRITE; strobes held stable throughout.
- mem_ready in any non-waiting state is ignored.
- funct changes only on DECODE→next edge; stable through EXEC.

## Structure
- Shared package ctrl_pkg: state encodings, opcode constants, alu_op codes (ALU_ADD, ALU_SUB, ALU_FUNCT), src_a/src_b select constants; the ALU control decoder imports the same alu_op codes.
- Single module: state register, next-state logic, output decode; no sub-module.

## Test plan
- add (funct7=0000000, funct3=000), mem_ready=1 -> states 0,1,6,7,0; alu_op=10 and funct=0000 in EXEC; reg_write=1 only in ALU_WB.
- sub (instr[30]=1) then and (funct3=111) -> funct=1000 then 0111 in EXEC.
- load with mem_ready low 3 cycles in MEM_READ -> mem_read, i_or_d held 4 cycles, then MEM_WB with mem_to_reg=1; total 8 cycles.
- beq -> BRANCH with alu_op=01, pc_write_cond=1, pc_source=1; return to FETCH after 3 cycles.
- opcode 1111111 -> TRAP, illegal=1, no enables, persists 20 cycles; reset_n low -> FETCH, illegal=0.
- reset_n asserted in MEM_WRITE -> immediately mem_write=0, state=0; after release a fresh fetch begins.
